// File: rtl/spi_pkg.sv
// Shared types and constants for the multi-slave SPI master.
package spi_pkg;

    // Frame sequencing: select asserted in LEAD, clocking in XFER, select held in TRAIL.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLead  = 2'd1,
        StXfer  = 2'd2,
        StTrail = 2'd3
    } spi_state_e;

    // Clock polarity: idle level of SCLK.
    localparam logic CPOL_LOW   = 1'b0;
    localparam logic CPOL_HIGH  = 1'b1;
    // Clock phase: which SCLK edge samples MISO.
    localparam logic CPHA_LEAD  = 1'b0;
    localparam logic CPHA_TRAIL = 1'b1;

endpackage

// File: rtl/spi_half_tick.sv
// Half-period divider: one-cycle tick every HALF_DIV GCLK cycles, held at zero while clr.
module spi_half_tick #(
    parameter int unsigned HALF_DIV = 50
) (
    input  logic GCLK,
    input  logic RST,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CNT_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    assign tick = !clr && (cnt_q == LAST);

    // Free-running count while a frame is active, restarting after each tick.
    always_ff @(posedge GCLK or posedge RST) begin
        if (RST) begin
            cnt_q <= '0;
        end else if (clr || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/spi_master_multi.sv
// SPI master with N_SS slave selects, run-time CPOL/CPHA and bit order.
// Optional build macro SPI_LOOPBACK_EN adds a 'loopback' input that routes MOSI
// back into the receiver while keeping selects inactive and SCLK parked.
module spi_master_multi
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned HALF_DIV = 50,
    parameter int unsigned N_SS     = 4,
    localparam int unsigned SS_W    = (N_SS > 1) ? $clog2(N_SS) : 1
) (
    input  logic              GCLK,
    input  logic              RST,
    input  logic              start,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsb_first,
    input  logic [SS_W-1:0]   ss_sel,
    input  logic [DATA_W-1:0] tx_data,
`ifdef SPI_LOOPBACK_EN
    input  logic              loopback,
`endif
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              SCLK,
    output logic              MOSI,
    input  logic              MISO,
    output logic [N_SS-1:0]   SS_N
);

    localparam int unsigned EDGE_W = $clog2(2 * DATA_W);
    localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W - 1);

    spi_state_e        state_q, state_d;
    logic [DATA_W-1:0] tx_sr_q, rx_sr_q, rx_data_q;
    logic [EDGE_W-1:0] edge_q;
    logic [SS_W-1:0]   ss_q;
    logic              cpol_q, cpha_q, lsb_q, sclk_q, rx_valid_q, lb_q;
    logic              tick, tick_clr, ss_ok, accept, xfer_tick, lead_edge;
    logic              do_sample, do_shift, miso_int;

    assign tick_clr  = (state_q == StIdle);
    assign ss_ok     = 32'(ss_sel) < N_SS;
    assign accept    = start && (state_q == StIdle) && ss_ok;
    assign xfer_tick = (state_q == StXfer) && tick;
    // Even edge numbers are leading edges (first move away from the idle level).
    assign lead_edge = ~edge_q[0];
    assign do_sample = xfer_tick && ((cpha_q == CPHA_LEAD) ? lead_edge : !lead_edge);
    // With CPHA=1 the first leading edge presents bit 0, which is already on MOSI.
    assign do_shift  = xfer_tick && ((cpha_q == CPHA_LEAD) ? !lead_edge
                                                           : (lead_edge && edge_q != '0));

    spi_half_tick #(
        .HALF_DIV (HALF_DIV)
    ) u_half_tick (
        .GCLK (GCLK),
        .RST  (RST),
        .clr  (tick_clr),
        .tick (tick)
    );

`ifdef SPI_LOOPBACK_EN
    // Loopback mode is captured with the rest of the frame configuration.
    always_ff @(posedge GCLK or posedge RST) begin
        if (RST) begin
            lb_q <= 1'b0;
        end else if (accept) begin
            lb_q <= loopback;
        end
    end
`else
    assign lb_q = 1'b0;
`endif

    assign miso_int = lb_q ? MOSI : MISO;

    // State register.
    always_ff @(posedge GCLK or posedge RST) begin
        if (RST) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: each phase advances on the divider tick.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StLead;
            StLead:  if (tick) state_d = StXfer;
            StXfer:  if (tick && edge_q == LAST_EDGE) state_d = StTrail;
            StTrail: if (tick) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Frame configuration capture, shift registers, SCLK generation and completion pulse.
    always_ff @(posedge GCLK or posedge RST) begin
        if (RST) begin
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            rx_data_q  <= '0;
            edge_q     <= '0;
            ss_q       <= '0;
            cpol_q     <= CPOL_LOW;
            cpha_q     <= CPHA_LEAD;
            lsb_q      <= 1'b0;
            sclk_q     <= CPOL_LOW;
            rx_valid_q <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            if (accept) begin
                tx_sr_q <= tx_data;
                rx_sr_q <= '0;
                edge_q  <= '0;
                ss_q    <= ss_sel;
                cpol_q  <= cpol;
                cpha_q  <= cpha;
                lsb_q   <= lsb_first;
            end
            if (state_q == StIdle) begin
                sclk_q <= cpol;
            end else if (xfer_tick && !lb_q) begin
                sclk_q <= ~sclk_q;
            end
            if (xfer_tick) begin
                edge_q <= edge_q + 1'b1;
            end
            if (do_shift) begin
                tx_sr_q <= lsb_q ? (tx_sr_q >> 1) : (tx_sr_q << 1);
            end
            if (do_sample) begin
                rx_sr_q <= lsb_q ? {miso_int, rx_sr_q[DATA_W-1:1]}
                                 : {rx_sr_q[DATA_W-2:0], miso_int};
            end
            if (state_q == StTrail && tick) begin
                rx_data_q  <= rx_sr_q;
                rx_valid_q <= 1'b1;
            end
        end
    end

    // Active-low select for the latched target only; loopback keeps every select idle.
    always_comb begin
        SS_N = '1;
        if (state_q != StIdle && !lb_q) begin
            SS_N[ss_q] = 1'b0;
        end
    end

    assign MOSI     = (state_q != StIdle) && (lsb_q ? tx_sr_q[0] : tx_sr_q[DATA_W-1]);
    assign SCLK     = sclk_q;
    assign busy     = (state_q != StIdle);
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

endmodule

// File: doc/spi_master_multi.md
SPI_MASTER_MULTI -- requirements
Module: spi_master_multi

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning bits per frame (legal 2..32).
REQ-002 SHALL have parameter HALF_DIV, default 50, meaning GCLK cycles per SCLK half-period (legal >=1).
REQ-003 SHALL have parameter N_SS, default 4, meaning number of slave-select lines (legal 1..8).
REQ-004 SHALL have port GCLK  in  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port RST  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports start in 1 (frame request), cpol in 1, cpha in 1, lsb_first in 1, ss_sel in clog2(N_SS) (target slave), tx_data in DATA_W.
REQ-007 SHALL have ports rx_data out DATA_W (last received frame), rx_valid out 1 (one-cycle done pulse), busy out 1.
REQ-008 SHALL have ports SCLK out 1, MOSI out 1, MISO in 1, SS_N out N_SS (active-low selects).

Function
REQ-009 SHALL implement states IDLE, LEAD, XFER, TRAIL; IDLE->LEAD on accepted start, LEAD->XFER after one half-period, XFER->TRAIL after 2*DATA_W half-periods, TRAIL->IDLE after one half-period.
REQ-010 SHALL accept start only in IDLE with ss_sel < N_SS; otherwise ignore it with no output change.
REQ-011 SHALL latch tx_data, cpol, cpha, lsb_first, ss_sel on the accepting cycle; later input changes have no effect on the frame.
REQ-012 SHALL assert busy from the cycle after acceptance until leaving TRAIL: exactly HALF_DIV*(2*DATA_W+2) cycles.
REQ-013 SHALL drive SS_N[ss_sel] low during LEAD, XFER, TRAIL; all other SS_N bits high at all times.
REQ-014 SHALL hold SCLK at cpol in IDLE (registered, one-cycle follow), LEAD and TRAIL; toggle every HALF_DIV cycles in XFER, 2*DATA_W edges.
REQ-015 SHALL, with cpha=0, present bit 0 on MOSI on LEAD entry, sample MISO on each leading edge, shift MOSI on each trailing edge.
REQ-016 SHALL, with cpha=1, shift MOSI on each leading edge and sample MISO on each trailing edge.
REQ-017 SHALL send MSB first when lsb_first=0, LSB first when 1; rx_data assembled in the same bit order.
REQ-018 SHALL update rx_data and pulse rx_valid for one cycle on the cycle busy falls.
REQ-019 SHALL drive MOSI 0 in IDLE.
REQ-020 SHALL allow back-to-back frames: start high in the rx_valid cycle is accepted the next cycle (IDLE).

Reset
REQ-021 SHALL on RST force IDLE, busy=0, rx_valid=0, rx_data=0, SCLK=0, MOSI=0, SS_N all 1, divider counter 0, regardless of state.
REQ-022 SHALL abort any frame in progress on RST with no rx_valid pulse.

Configuration
REQ-023 SHALL, when SPI_LOOPBACK_EN is defined, add input loopback (1 bit); when loopback=1 MISO sampling uses internal MOSI, SS_N stays all 1, SCLK stays at cpol.
REQ-024 SHALL, without SPI_LOOPBACK_EN, have no loopback port and always sample MISO.

Structure
REQ-025 SHALL place the state enum and mode constants (CPOL/CPHA encodings) in shared package spi_pkg.
REQ-026 SHALL use one sub-module spi_half_tick: HALF_DIV counter producing a one-cycle tick, cleared on IDLE.

Verification
REQ-027 DATA_W=8, HALF_DIV=2, mode 0, MSB first, tx=0xA5, MISO tied to MOSI -> MOSI 1,0,1,0,0,1,0,1; rx_data=0xA5; busy 36 cycles.
REQ-028 Mode 3 (cpol=1,cpha=1), tx=0x3C, slave model returns 0xC3 -> SCLK idles 1, rx_data=0xC3, SS_N=4'b1101 for ss_sel=1.
REQ-029 lsb_first=1, tx=0x01 -> first MOSI bit 1, remaining 0; external MISO 0x80 LSB-first gives rx_data=0x80.
REQ-030 start held during busy and ss_sel=5 with N_SS=4 -> ignored; exactly one rx_valid per accepted frame.
REQ-031 RST asserted mid-XFER at bit 3 -> next cycle SS_N=4'b1111, SCLK=0, busy=0, no rx_valid, rx_data unchanged 0.
REQ-032 SPI_LOOPBACK_EN defined, loopback=1, tx=0x5A -> rx_data=0x5A, SS_N all 1, SCLK constant.
